rv_exec_sequencer: RTL and testbench
====================================

# rv_exec_sequencer

Multi-cycle execution sequencer for the RV32I core. Accepts one decoded instruction at a time over a valid/ready handshake. Sequences register-file reads through a single synchronous read port, drives the shared ALU, and commits the result through the register-file write port. Sits between the decoder/control unit and the register file plus ALU, replacing combinational load/compute/store with an explicit FSM.

## Interface
- No parameters. XLEN fixed at 32, register index width fixed at 5.
- Clock/reset (already decided): one clock; reset is asynchronous and active-high.
  - `clk` in 1: the single clock.
  - `rst` in 1: asynchronous, active-high reset.
- Issue side (decoder/control):
  - `issue_valid` in 1: decoded instruction present.
  - `issue_ready` out 1: sequencer can accept.
  - `inst_type` in 3: 000 R, 001 U (LUI), 011 I-ALU. All other values are illegal.
  - `alu_ctrl` in 4: ALU operation code, passed through to `alu_op`.
  - `shamt_en` in 1: I-type shift; the immediate becomes a 5-bit shift amount.
  - `rd`, `rs1`, `rs2` in 5 each: register indices.
  - `imm_I` in 12: I-type immediate.
  - `imm_U` in 20: U-type immediate.
- Register-file read port:
  - `rf_re` out 1: read enable.
  - `rf_raddr` out 5: read address.
  - `rf_rdata` in 32: read data, valid the cycle after `rf_re`.
- Register-file write port:
  - `rf_we` out 1: write enable.
  - `rf_waddr` out 5: write address.
  - `rf_wdata` out 32: write data.
- ALU (combinational):
  - `alu_a`, `alu_b` out 32 each: operands.
  - `alu_op` out 4: operation.
  - `alu_result` in 32: result.
- Status:
  - `busy` out 1: state is not IDLE.
  - `done` out 1: one-cycle pulse on commit.
  - `illegal` out 1: one-cycle pulse when an unsupported `inst_type` is dropped.

## Operation
- States: IDLE, RS1, RS2, EXEC, WB, ERR.
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`, latch all instruction fields.
  - Legal type → RS1. Illegal type → ERR.
- RS1: `rf_re`=1, `rf_raddr`=rs1 → RS2.
- RS2:
  - `op_a` <= `rf_rdata`.
  - R-type: `rf_re`=1, `rf_raddr`=rs2.
  - Other types: `rf_re`=0.
  - → EXEC.
- EXEC:
  - `alu_a`=`op_a`, `alu_op`=latched `alu_ctrl`.
  - `alu_b` source:
    - R-type: `rf_rdata`.
    - I-type, `shamt_en`=0: sign-extended `imm_I`.
    - I-type, `shamt_en`=1: {27'b0, imm_I[4:0]}.
  - `res` <= `alu_result`. For U-type, `res` <= {imm_U, 12'b0} and the ALU output is ignored.
  - → WB.
- WB:
  - `rf_waddr`=rd, `rf_wdata`=res, `done`=1.
  - `rf_we`=1 only if rd != 0 (x0 is never written).
  - → IDLE.
- ERR: `illegal`=1, no register-file access → IDLE.
- Outputs outside their active state: `rf_re`, `rf_we`, `done`, `illegal` are 0; `alu_a`/`alu_b` are 0; `rf_*addr` are 0.

## Timing
- Reset value of every output is 0, except `issue_ready`=1.
- Reset asserted mid-instruction: FSM → IDLE immediately and asynchronously; `rf_we` drops in the same cycle; the in-flight instruction is discarded with no `done`.
- Latency, with accept at cycle 0:
  - R/I: RS1 cycle 1, RS2 cycle 2, EXEC cycle 3, WB (`done`) cycle 4; next accept possible at cycle 5.
  - Illegal: `illegal` pulses at cycle 1.
- `issue_ready` is 0 from cycle 1 until the cycle after WB/ERR. A `issue_valid` asserted in that window is not accepted and must be held by the sender.
- Fields are sampled only at the accept edge. Changes to the issue inputs after acceptance have no effect.
- rs1==rs2 needs no special handling; both reads are issued.
- rd==0: `done` still pulses; `rf_we` stays 0.

## Configuration
- `RV_SEQ_LUI_FAST_EN` defined: U-type goes IDLE→EXEC→WB with no register-file reads. `done` arrives at cycle 2.
- `RV_SEQ_LUI_FAST_EN` undefined: U-type traverses RS1/RS2 like I-type (rs1 is read but unused). `done` arrives at cycle 4.

## Structure
- Package `rv_pkg` holds:
  - `inst_type` encodings (INST_R, INST_U, INST_I).
  - `alu_ctrl` encodings (ADD 0010, SUB 0100, SLL 0011, SLT 1000, XOR 0111, SRL 0101, SRA 1001, OR 0001, AND 0000).
  - The FSM state enum.
- Sub-module `rv_imm_gen`: combinational I/U immediate extension and shamt masking, reused by later branch/jump work.

## Test plan
- R-type ADD, x1=5, x2=7, rd=3 → `rf_re` cycles 1–2 with addresses 1 then 2; `alu_b`=7 at cycle 3; cycle 4 `rf_we`=1, `rf_waddr`=3, `rf_wdata`=12, `done`=1.
- I-type ADD, x1=0x10, imm_I=0xFFF → `alu_b`=0xFFFFFFFF; write 0x0000000F; no read at cycle 2.
- I-type SRL with `shamt_en`, imm_I=0x423 → `alu_b`=3.
- LUI, imm_U=0xABCDE, rd=5 → `rf_wdata`=0xABCDE000 at cycle 2 with the macro, cycle 4 without.
- rd=0 with R-type → `done`=1, `rf_we`=0. `inst_type`=111 → `illegal` at cycle 1, no `rf_re`/`rf_we`.
- `rst` asserted at cycle 3 (EXEC) → all outputs 0, `issue_ready`=1 in the same cycle, no `done`. `issue_valid` held during busy → accepted exactly at cycle 5.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I execution sequencer: instruction classes,
// ALU operation codes, FSM states and the latched instruction payload.
package rv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned IMM_I_W = 12;
  localparam int unsigned IMM_U_W = 20;

  localparam logic [TYPE_W-1:0] INST_R = 3'b000;
  localparam logic [TYPE_W-1:0] INST_U = 3'b001;
  localparam logic [TYPE_W-1:0] INST_I = 3'b011;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RS1  = 3'd1,
    ST_RS2  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

  // Instruction fields held for the whole sequence. rs1 is absent because it
  // is only needed on the accept edge, where it comes straight from the port.
  typedef struct packed {
    logic [TYPE_W-1:0]  itype;
    logic [ALU_W-1:0]   alu_ctrl;
    logic               shamt_en;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs2;
    logic [IMM_I_W-1:0] imm_i;
    logic [IMM_U_W-1:0] imm_u;
  } inst_t;

  // Instruction classes the sequencer knows how to execute.
  function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
    return (t == INST_R) || (t == INST_U) || (t == INST_I);
  endfunction

  // ALU codes understood by the shared ALU.
  function automatic logic is_known_alu(input logic [ALU_W-1:0] op);
    return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
           (op == ALU_SLL) || (op == ALU_SUB) || (op == ALU_SRL) ||
           (op == ALU_XOR) || (op == ALU_SLT) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extension: sign-extended I immediate (or 5-bit shift amount)
// and the left-justified U immediate.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [IMM_I_W-1:0] i_imm_i,
  input  logic [IMM_U_W-1:0] i_imm_u,
  input  logic               i_shamt_en,
  output logic [XLEN-1:0]    o_imm_i_ext,
  output logic [XLEN-1:0]    o_imm_u_ext
);

  localparam int unsigned SHAMT_W = 5;

  logic [XLEN-1:0] w_imm_i_sext;
  logic [XLEN-1:0] w_shamt;

  assign w_imm_i_sext = {{(XLEN-IMM_I_W){i_imm_i[IMM_I_W-1]}}, i_imm_i};
  assign w_shamt      = {{(XLEN-SHAMT_W){1'b0}}, i_imm_i[SHAMT_W-1:0]};

  assign o_imm_i_ext  = i_shamt_en ? w_shamt : w_imm_i_sext;
  assign o_imm_u_ext  = {i_imm_u, {(XLEN-IMM_U_W){1'b0}}};

endmodule

// File: rtl/rv_exec_sequencer.sv
// Multi-cycle execution sequencer: reads operands through one synchronous
// register-file read port, drives the shared ALU and commits through the
// write port. Define RV_SEQ_LUI_FAST_EN to send LUI straight to EXEC.
// Outputs are registered from the next state, except alu_b, which must
// forward rf_rdata combinationally in EXEC for R-type.
module rv_exec_sequencer
  import rv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [2:0]         inst_type,
  input  logic [3:0]         alu_ctrl,
  input  logic               shamt_en,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [11:0]        imm_I,
  input  logic [19:0]        imm_U,
  output logic               rf_re,
  output logic [4:0]         rf_raddr,
  input  logic [31:0]        rf_rdata,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [3:0]         alu_op,
  input  logic [31:0]        alu_result,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  seq_state_t r_state;
  seq_state_t w_next;
  inst_t      r_inst;

  logic              w_accept;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_alu_b;

  logic              w_ready_n;
  logic              w_rf_re_n;
  logic [REG_W-1:0]  w_rf_raddr_n;
  logic              w_rf_we_n;
  logic [REG_W-1:0]  w_rf_waddr_n;
  logic [XLEN-1:0]   w_rf_wdata_n;
  logic [XLEN-1:0]   w_alu_a_n;
  logic [ALU_W-1:0]  w_alu_op_n;
  logic              w_done_n;
  logic              w_illegal_n;

  assign w_accept = (r_state == ST_IDLE) && issue_valid;

  rv_imm_gen u_imm_gen (
    .i_imm_i     (r_inst.imm_i),
    .i_imm_u     (r_inst.imm_u),
    .i_shamt_en  (r_inst.shamt_en),
    .o_imm_i_ext (w_imm_i),
    .o_imm_u_ext (w_imm_u)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Capture the instruction fields on the accept edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst <= '0;
    end else if (w_accept) begin
      r_inst <= '{itype:    inst_type,
                  alu_ctrl: alu_ctrl,
                  shamt_en: shamt_en,
                  rd:       rd,
                  rs2:      rs2,
                  imm_i:    imm_I,
                  imm_u:    imm_U};
    end
  end

  // Next state, then the output values for the cycle spent in that state.
  always_comb begin
    w_next       = r_state;
    w_ready_n    = 1'b0;
    w_rf_re_n    = 1'b0;
    w_rf_raddr_n = '0;
    w_rf_we_n    = 1'b0;
    w_rf_waddr_n = '0;
    w_rf_wdata_n = '0;
    w_alu_a_n    = '0;
    w_alu_op_n   = '0;
    w_done_n     = 1'b0;
    w_illegal_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (issue_valid) begin
          if (!is_legal_type(inst_type)) w_next = ST_ERR;
`ifdef RV_SEQ_LUI_FAST_EN
          else if (inst_type == INST_U)  w_next = ST_EXEC;
`endif
          else                           w_next = ST_RS1;
        end
      end
      ST_RS1:  w_next = ST_RS2;
      ST_RS2:  w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase

    case (w_next)
      ST_IDLE: w_ready_n = 1'b1;
      ST_RS1: begin
        w_rf_re_n    = 1'b1;
        w_rf_raddr_n = rs1;
      end
      ST_RS2: begin
        w_rf_re_n    = (r_inst.itype == INST_R);
        w_rf_raddr_n = (r_inst.itype == INST_R) ? r_inst.rs2 : REG_W'(0);
      end
      ST_EXEC: begin
        // alu_a doubles as op_a; the fast LUI path never reads rs1.
        w_alu_a_n  = (r_state == ST_RS2) ? rf_rdata : XLEN'(0);
        w_alu_op_n = (r_state == ST_IDLE) ? alu_ctrl : r_inst.alu_ctrl;
      end
      ST_WB: begin
        w_rf_we_n    = (r_inst.rd != REG_W'(0));
        w_rf_waddr_n = r_inst.rd;
        w_rf_wdata_n = (r_inst.itype == INST_U) ? w_imm_u : alu_result;
        w_done_n     = 1'b1;
      end
      ST_ERR:  w_illegal_n = 1'b1;
      default: w_ready_n   = 1'b0;
    endcase
  end

  // Second ALU operand, live only in EXEC.
  always_comb begin
    w_alu_b = '0;
    if (r_state == ST_EXEC) begin
      case (r_inst.itype)
        INST_R:  w_alu_b = rf_rdata;
        INST_I:  w_alu_b = w_imm_i;
        default: w_alu_b = w_imm_u;
      endcase
    end
  end

  assign alu_b = w_alu_b;

  // Output registers; reset clears everything mid-flight, including rf_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_ready <= 1'b1;
      busy        <= 1'b0;
      rf_re       <= 1'b0;
      rf_raddr    <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      alu_a       <= '0;
      alu_op      <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      issue_ready <= w_ready_n;
      busy        <= !w_ready_n;
      rf_re       <= w_rf_re_n;
      rf_raddr    <= w_rf_raddr_n;
      rf_we       <= w_rf_we_n;
      rf_waddr    <= w_rf_waddr_n;
      rf_wdata    <= w_rf_wdata_n;
      alu_a       <= w_alu_a_n;
      alu_op      <= w_alu_op_n;
      done        <= w_done_n;
      illegal     <= w_illegal_n;
    end
  end

endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Bench for rv_exec_sequencer: a register file and ALU around the DUT, plus an
// instruction-level reference (shadow registers and RV32I arithmetic).
module tb_rv_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  inst_type;
  logic [3:0]  alu_ctrl;
  logic        shamt_en;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_I;
  logic [19:0] imm_U;
  logic        rf_re, rf_we;
  logic [4:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        busy, done, illegal;

`ifdef RV_SEQ_LUI_FAST_EN
  localparam int LAT_U = 2;
`else
  localparam int LAT_U = 4;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rv_exec_sequencer dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .inst_type(inst_type), .alu_ctrl(alu_ctrl), .shamt_en(shamt_en),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm_I(imm_I), .imm_U(imm_U),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .illegal(illegal)
  );

  // RV32I ALU semantics
  function automatic logic [31:0] sem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0100: return a - b;
      4'b0011: return a << b[4:0];
      4'b1000: return {31'b0, ($signed(a) < $signed(b))};
      4'b0111: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1001: return $signed(a) >>> b[4:0];
      4'b0001: return a | b;
      4'b0000: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  // Environment: register file with a bench preload port, and the ALU
  logic [31:0] env_rf [32];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (rf_re) rf_rdata <= env_rf[rf_raddr];
    if (rf_we) env_rf[rf_waddr] <= rf_wdata;
    if (pl_we) env_rf[pl_addr] <= pl_data;
  end

  always_comb alu_result = sem(alu_op, alu_a, alu_b);

  // Reference model state
  logic [31:0] m_rf [32];
  logic [3:0]  codes [9] = '{4'b0010, 4'b0100, 4'b0011, 4'b1000, 4'b0111,
                             4'b0101, 4'b1001, 4'b0001, 4'b0000};

  function automatic logic [31:0] expect_wb(input logic [2:0] t, input logic [3:0] op,
      input logic sh, input logic [4:0] s1, input logic [4:0] s2,
      input logic [11:0] ii, input logic [19:0] iu);
    logic [31:0] b;
    if (t == 3'b001) return {iu, 12'h000};
    if (t == 3'b000) return sem(op, m_rf[s1], m_rf[s2]);
    b = sh ? 32'(ii[4:0]) : 32'($signed(ii));
    return sem(op, m_rf[s1], b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [3:0] op, input logic sh,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [11:0] ii, input logic [19:0] iu);
    inst_type = t; alu_ctrl = op; shamt_en = sh;
    rd = d; rs1 = s1; rs2 = s2; imm_I = ii; imm_U = iu;
    issue_valid = 1'b1;
  endtask

  task automatic scramble();
    inst_type = 3'($urandom); alu_ctrl = 4'($urandom); shamt_en = 1'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm_I = 12'($urandom); imm_U = 20'($urandom);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = (a == 5'd0) ? 32'h0 : d;
    m_rf[a] = (a == 5'd0) ? 32'h0 : d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!issue_ready && k < 20) begin step(); k++; end
    check("wait_ready", 32'(issue_ready), 32'd1);
  endtask

  // One randomized instruction checked end to end
  task automatic run_random(input int idx);
    logic [2:0]  t;
    logic [3:0]  op;
    logic        sh;
    logic [4:0]  d, s1, s2;
    logic [11:0] ii;
    logic [19:0] iu;
    logic [31:0] exp_v;
    int          sel, lat, c;
    logic        bad;
    sel = int'($urandom_range(0, 9));
    if (sel <= 3)      t = 3'b000;
    else if (sel <= 6) t = 3'b011;
    else if (sel <= 8) t = 3'b001;
    else begin
      t = 3'b111;
      while (t == 3'b000 || t == 3'b001 || t == 3'b011) t = 3'($urandom);
    end
    bad = !(t == 3'b000 || t == 3'b001 || t == 3'b011);
    op = codes[$urandom_range(0, 8)];
    sh = 1'($urandom); d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    ii = 12'($urandom); iu = 20'($urandom);
    exp_v = expect_wb(t, op, sh, s1, s2, ii, iu);
    lat = bad ? 1 : ((t == 3'b001) ? LAT_U : 4);
    wait_ready();
    drive(t, op, sh, d, s1, s2, ii, iu);
    step();
    issue_valid = 1'b0;
    scramble();
    c = 1;
    while (!(done || illegal) && c < 8) begin step(); c++; end
    check($sformatf("rnd%0d_latency", idx), 32'(c), 32'(lat));
    if (bad) begin
      check($sformatf("rnd%0d_illegal", idx), 32'(illegal), 32'd1);
      check($sformatf("rnd%0d_ill_we", idx), 32'(rf_we), 32'd0);
    end else begin
      check($sformatf("rnd%0d_done", idx), 32'(done), 32'd1);
      check($sformatf("rnd%0d_waddr", idx), 32'(rf_waddr), 32'(d));
      check($sformatf("rnd%0d_wdata", idx), rf_wdata, exp_v);
      check($sformatf("rnd%0d_we", idx), 32'(rf_we), 32'(d != 5'd0));
      if (d != 5'd0) m_rf[d] = exp_v;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0;
    inst_type = '0; alu_ctrl = '0; shamt_en = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm_I = '0; imm_U = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_rf_re", 32'(rf_re), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 32; i++) preload(5'(i), $urandom);

    // R-type ADD x3 = x1 + x2
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    drive(3'b000, 4'b0010, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 20'h0);
    step();
    issue_valid = 1'b0;
    check("r_c1_re", 32'(rf_re), 32'd1);
    check("r_c1_raddr", 32'(rf_raddr), 32'd1);
    check("r_c1_ready", 32'(issue_ready), 32'd0);
    check("r_c1_busy", 32'(busy), 32'd1);
    step();
    check("r_c2_re", 32'(rf_re), 32'd1);
    check("r_c2_raddr", 32'(rf_raddr), 32'd2);
    step();
    check("r_c3_alu_a", alu_a, 32'd5);
    check("r_c3_alu_b", alu_b, 32'd7);
    check("r_c3_alu_op", 32'(alu_op), 32'h2);
    step();
    check("r_c4_we", 32'(rf_we), 32'd1);
    check("r_c4_waddr", 32'(rf_waddr), 32'd3);
    check("r_c4_wdata", rf_wdata, 32'd12);
    check("r_c4_done", 32'(done), 32'd1);
    m_rf[3] = 32'd12;
    step();
    check("r_c5_done", 32'(done), 32'd0);
    check("r_c5_ready", 32'(issue_ready), 32'd1);

    // I-type ADD with negative immediate
    preload(5'd1, 32'h10);
    drive(3'b011, 4'b0010, 1'b0, 5'd4, 5'd1, 5'd9, 12'hFFF, 20'h0);
    step();
    issue_valid = 1'b0;
    step();
    check("i_c2_no_read", 32'(rf_re), 32'd0);
    step();
    check("i_c3_alu_b", alu_b, 32'hFFFF_FFFF);
    step();
    check("i_c4_wdata", rf_wdata, 32'h0000_000F);
    check("i_c4_done", 32'(done), 32'd1);
    m_rf[4] = 32'h0000_000F;
    step();

    // I-type SRL with shift amount masking
    preload(5'd1, 32'h8000_0000);
    drive(3'b011, 4'b0101, 1'b1, 5'd6, 5'd1, 5'd0, 12'h423, 20'h0);
    step();
    issue_valid = 1'b0;
    step(); step();
    check("srl_c3_alu_b", alu_b, 32'd3);
    step();
    check("srl_c4_wdata", rf_wdata, 32'h1000_0000);
    m_rf[6] = 32'h1000_0000;
    step();

    // LUI
    drive(3'b001, 4'b0000, 1'b0, 5'd5, 5'd1, 5'd2, 12'h0, 20'hABCDE);
    step();
    issue_valid = 1'b0;
    check("lui_c1_re", 32'(rf_re), (LAT_U == 2) ? 32'd0 : 32'd1);
    check("lui_c1_done", 32'(done), 32'd0);
    repeat (LAT_U - 1) step();
    check("lui_done", 32'(done), 32'd1);
    check("lui_wdata", rf_wdata, 32'hABCD_E000);
    check("lui_waddr", 32'(rf_waddr), 32'd5);
    m_rf[5] = 32'hABCD_E000;
    step();

    // R-type with rd = x0
    drive(3'b000, 4'b0010, 1'b0, 5'd0, 5'd1, 5'd2, 12'h0, 20'h0);
    step();
    issue_valid = 1'b0;
    repeat (3) step();
    check("x0_done", 32'(done), 32'd1);
    check("x0_we", 32'(rf_we), 32'd0);
    step();

    // Illegal instruction type
    drive(3'b111, 4'b0010, 1'b0, 5'd7, 5'd1, 5'd2, 12'h0, 20'h0);
    step();
    issue_valid = 1'b0;
    check("ill_c1_illegal", 32'(illegal), 32'd1);
    check("ill_c1_re", 32'(rf_re), 32'd0);
    check("ill_c1_we", 32'(rf_we), 32'd0);
    check("ill_c1_done", 32'(done), 32'd0);
    step();
    check("ill_c2_illegal", 32'(illegal), 32'd0);
    check("ill_c2_ready", 32'(issue_ready), 32'd1);

    // Reset in EXEC discards the instruction
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    drive(3'b000, 4'b0010, 1'b0, 5'd8, 5'd1, 5'd2, 12'h0, 20'h0);
    step();
    issue_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(issue_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_we", 32'(rf_we), 32'd0);
    check("mrst_alu_a", alu_a, 32'h0);
    check("mrst_alu_b", alu_b, 32'h0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("mrst_no_done%0d", k), 32'(done), 32'd0);
    end

    // Instruction held during busy, accepted at cycle 5
    preload(5'd10, 32'd100);
    preload(5'd11, 32'd23);
    drive(3'b000, 4'b0100, 1'b0, 5'd12, 5'd10, 5'd11, 12'h0, 20'h0);
    step();
    drive(3'b011, 4'b0010, 1'b0, 5'd13, 5'd12, 5'd0, 12'd5, 20'h0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("hold_c%0d_ready", c), 32'(issue_ready), 32'd0);
      if (c < 4) step();
    end
    check("hold_a_wdata", rf_wdata, 32'd77);
    check("hold_a_waddr", 32'(rf_waddr), 32'd12);
    m_rf[12] = 32'd77;
    step();
    check("hold_c5_ready", 32'(issue_ready), 32'd1);
    check("hold_c5_re", 32'(rf_re), 32'd0);
    step();
    issue_valid = 1'b0;
    check("hold_b_c1_re", 32'(rf_re), 32'd1);
    check("hold_b_c1_raddr", 32'(rf_raddr), 32'd12);
    repeat (3) step();
    check("hold_b_done", 32'(done), 32'd1);
    check("hold_b_wdata", rf_wdata, 32'd82);
    check("hold_b_waddr", 32'(rf_waddr), 32'd13);
    m_rf[13] = 32'd82;
    step();

    // Randomized instructions against the reference model
    for (int i = 0; i < 40; i++) run_random(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
